// File: rtl/alu_pkg.sv
// Shared ALU definitions: state encodings for the leading-zero/one
// normalizer and the CLZ/CLO mode selector values.
package alu_pkg;

    // Normalizer control states
    typedef enum logic [1:0] {
        LZN_IDLE = 2'd0,
        LZN_RUN  = 2'd1,
        LZN_DONE = 2'd2
    } lzn_state_e;

    // Count selector: leading zeros or leading ones
    localparam logic MODE_CLZ = 1'b0;
    localparam logic MODE_CLO = 1'b1;

    // Number of binary-search stages needed for an operand of width w
    function automatic int lzn_steps(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/lz_normalizer.sv
// Iterative binary-search CLZ/CLO unit. One search stage per clock: the
// stage examines the top 2**step bits of the working word and, if they
// are all zero, shifts both the working word and the original operand
// left by that amount. CLO is handled by searching the inverted operand
// while shifting the original one.
module lz_normalizer
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] norm,
    output logic             all_same
);

    localparam int STEPS = lzn_steps(WIDTH);
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    lzn_state_e state_reg, state_next;

    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] sh_reg;
    logic [CW-1:0]    cnt_reg;
    logic [SW-1:0]    step_reg;

    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] norm_reg;
    logic             all_same_reg;

    logic             load;
    logic             last_step;

    // Per-stage candidates, one per possible step value
    logic [STEPS-1:0] hit;
    logic [WIDTH-1:0] work_sh [STEPS];
    logic [WIDTH-1:0] sh_sh   [STEPS];

    // Selected stage results for the current step
    logic             stage_hit;
    logic [CW-1:0]    k_val;
    logic [WIDTH-1:0] work_step;
    logic [WIDTH-1:0] sh_step;
    logic [CW-1:0]    cnt_step;
    logic             final_zero;
    logic [CW-1:0]    fin_cnt;
    logic [WIDTH-1:0] fin_norm;

    // Each stage tests a window of 2**gi leading bits and precomputes its shift
    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_stage
            localparam int K = 2 ** gi;
            assign hit[gi]     = (work_reg[WIDTH-1 -: K] == '0);
            assign work_sh[gi] = work_reg << K;
            assign sh_sh[gi]   = sh_reg << K;
        end
    endgenerate

    // Start is honoured only when no search is in flight
    assign load      = start && (state_reg != LZN_RUN);
    assign last_step = (state_reg == LZN_RUN) && (step_reg == '0);

    // Pick the active stage and apply the all-zero fix-up after the final step
    always_comb begin
        stage_hit = hit[step_reg];
        k_val     = CW'(1) << step_reg;
        work_step = work_reg;
        sh_step   = sh_reg;
        cnt_step  = cnt_reg;
        if (stage_hit) begin
            work_step = work_sh[step_reg];
            sh_step   = sh_sh[step_reg];
            cnt_step  = cnt_reg + k_val;
        end
        // After step 0 the MSB can only still be clear if the word was all zero
        final_zero = ~work_step[WIDTH-1];
        fin_cnt    = final_zero ? CW'(WIDTH) : cnt_step;
        fin_norm   = final_zero ? '0 : sh_step;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LZN_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            LZN_IDLE: if (start) state_next = LZN_RUN;
            LZN_RUN:  if (step_reg == '0) state_next = LZN_DONE;
            LZN_DONE: state_next = start ? LZN_RUN : LZN_IDLE;
            default:  state_next = LZN_IDLE;
        endcase
    end

    // Search datapath: load on accepted start, advance one stage per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg <= '0;
            sh_reg   <= '0;
            cnt_reg  <= '0;
            step_reg <= '0;
        end else if (load) begin
            work_reg <= (mode == MODE_CLO) ? ~in : in;
            sh_reg   <= in;
            cnt_reg  <= '0;
            step_reg <= SW'(STEPS - 1);
        end else if (state_reg == LZN_RUN) begin
            work_reg <= work_step;
            sh_reg   <= sh_step;
            cnt_reg  <= cnt_step;
            if (step_reg != '0) begin
                step_reg <= step_reg - SW'(1);
            end
        end
    end

    // Result registers: captured when the last stage completes, then held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            norm_reg     <= '0;
            all_same_reg <= 1'b0;
        end else if (last_step) begin
            count_reg    <= fin_cnt;
            norm_reg     <= fin_norm;
            all_same_reg <= (fin_cnt == CW'(WIDTH));
        end
    end

    assign busy     = (state_reg == LZN_RUN);
    assign done     = (state_reg == LZN_DONE);
    assign count    = count_reg;
    assign norm     = norm_reg;
    assign all_same = all_same_reg;

endmodule

// File: tb/tb_lz_normalizer.sv
// Directed and randomized checks for the leading-zero/one normalizer:
// reset values, handshake timing, CLZ/CLO results, ignored start during
// a search, back-to-back start, and asynchronous reset mid-search.
module tb_lz_normalizer;

    localparam int WIDTH = 32;
    localparam int CW    = 6;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] in_v;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] norm;
    logic             all_same;

    int checks = 0;
    int errors = 0;

    lz_normalizer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .in       (in_v),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .norm     (norm),
        .all_same (all_same)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: scan from the MSB for the first differing bit
    function automatic int ref_cnt(input logic m, input logic [31:0] v);
        logic [31:0] w;
        int n;
        w = m ? ~v : v;
        n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (w[i]) break;
            n++;
        end
        return n;
    endfunction

    // Called at the negedge on which start was raised. Follows six cycles,
    // checking busy/done each cycle, optionally pulsing start again during
    // RUN (cycle inj), then checks the results on the done cycle.
    task automatic track(input string tag, input logic m, input logic [31:0] v,
                         input int ec, input logic [31:0] en, input logic ea,
                         input int inj);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = (c == inj);
            if (c == inj) begin
                in_v = 32'h1;
                mode = 1'b0;
            end
            chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(c <= 5));
            chk($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == 6));
        end
        chk($sformatf("%s count", tag), 32'(count), 32'(ec));
        chk($sformatf("%s norm", tag), norm, en);
        chk($sformatf("%s all_same", tag), 32'(all_same), 32'(ea));
        $display("txn %s mode=%0d in=%08h count=%0d norm=%08h all_same=%0d",
                 tag, m, v, count, norm, all_same);
    endtask

    task automatic issue(input logic m, input logic [31:0] v);
        start = 1'b1;
        mode  = m;
        in_v  = v;
    endtask

    initial begin
        logic        rm;
        logic [31:0] rr;
        logic [31:0] rv;
        int          rc;

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        in_v  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst count", 32'(count), 32'h0);
        chk("rst norm", norm, 32'h0);
        chk("rst all_same", 32'(all_same), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: CLZ basic
        issue(1'b0, 32'h0001_0000);
        track("clz_0x10000", 1'b0, 32'h0001_0000, 15, 32'h8000_0000, 1'b0, 0);
        @(negedge clk);

        // 2: all-zero CLZ and all-one CLO
        issue(1'b0, 32'h0000_0000);
        track("clz_zero", 1'b0, 32'h0000_0000, 32, 32'h0, 1'b1, 0);
        @(negedge clk);
        issue(1'b1, 32'hFFFF_FFFF);
        track("clo_ones", 1'b1, 32'hFFFF_FFFF, 32, 32'h0, 1'b1, 0);
        @(negedge clk);

        // 3: CLO partial, CLZ with MSB set
        issue(1'b1, 32'hF0F0_0000);
        track("clo_f0f0", 1'b1, 32'hF0F0_0000, 4, 32'h0F00_0000, 1'b0, 0);
        @(negedge clk);
        issue(1'b0, 32'h8000_0000);
        track("clz_msb", 1'b0, 32'h8000_0000, 0, 32'h8000_0000, 1'b0, 0);
        @(negedge clk);

        // 4: start during RUN ignored, then back-to-back start on done cycle
        issue(1'b0, 32'h0001_0000);
        track("clz_ignore", 1'b0, 32'h0001_0000, 15, 32'h8000_0000, 1'b0, 2);
        issue(1'b0, 32'h0000_0001);
        track("clz_b2b", 1'b0, 32'h0000_0001, 31, 32'h8000_0000, 1'b0, 0);
        @(negedge clk);

        // 5: asynchronous reset in the middle of a search
        issue(1'b0, 32'h0000_0F00);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'h0);
        chk("midrst done", 32'(done), 32'h0);
        chk("midrst count", 32'(count), 32'h0);
        chk("midrst norm", norm, 32'h0);
        chk("midrst all_same", 32'(all_same), 32'h0);
        $display("txn midrst busy=%0d done=%0d count=%0d norm=%08h", busy, done, count, norm);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'h0000_0F00);
        track("clz_after_rst", 1'b0, 32'h0000_0F00, 20, 32'hF000_0000, 1'b0, 0);
        @(negedge clk);

        // 6: randomized operands in both modes against the reference
        for (int i = 0; i < 400; i++) begin
            rm = 1'($urandom_range(0, 1));
            rr = $urandom >> $urandom_range(0, 32);
            rv = rm ? ~rr : rr;
            rc = ref_cnt(rm, rv);
            issue(rm, rv);
            track($sformatf("rnd%0d", i), rm, rv, rc,
                  (rc == 32) ? 32'h0 : (rv << rc), (rc == 32), 0);
            if (i % 3 == 0) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
